// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store target with fixed access latency
// over a little-endian doubleword array, answering with a held rdata/err response.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    state_t      r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_write, r_unsigned, r_err;
    logic [1:0]  r_size;
    logic [63:0] r_addr, r_wdata, r_rdata;
    logic [63:0] r_mem [DEPTH];
    logic        w_exec, w_err;
    logic [2:0]  w_lane, w_amask;
    logic [7:0]  w_bmask, w_be;
    logic [63:0] w_wsh, w_raw, w_load;
    logic [AW-1:0] w_idx;
    assign w_lane  = r_addr[2:0];
    assign w_idx   = r_addr[AW+2:3];
    assign w_amask = r_size == 2'd0 ? 3'd0 : r_size == 2'd1 ? 3'd1 : r_size == 2'd2 ? 3'd3 : 3'd7;
    assign w_bmask = r_size == 2'd0 ? 8'h01 : r_size == 2'd1 ? 8'h03 : r_size == 2'd2 ? 8'h0F : 8'hFF;
    assign w_err   = (|(w_lane & w_amask)) || (r_addr[63:3] >= 61'(DEPTH));
    assign w_be    = w_bmask << w_lane;
    assign w_wsh   = r_wdata << {w_lane, 3'b000};
    assign w_raw   = r_mem[w_idx] >> {w_lane, 3'b000};
    assign w_exec  = r_state == BUSY && r_cnt == 4'd0;
    // Doubleword loads pass straight through, so req_unsigned has no effect there.
    assign w_load  = r_size == 2'd0 ? {{56{!r_unsigned && w_raw[7]}}, w_raw[7:0]} :
                     r_size == 2'd1 ? {{48{!r_unsigned && w_raw[15]}}, w_raw[15:0]} :
                     r_size == 2'd2 ? {{32{!r_unsigned && w_raw[31]}}, w_raw[31:0]} : w_raw;
    assign req_ready = r_state == IDLE && !reset;
    assign rsp_valid = r_state == RESP;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && req_valid) w_next = BUSY;
        if (w_exec) w_next = RESP;
        if (r_state == RESP && rsp_ready) w_next = IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= 64'd0;
            r_wdata    <= 64'd0;
            r_rdata    <= 64'd0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && req_valid) begin
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_size     <= req_size;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_cnt      <= 4'(LATENCY - 1);
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_exec) begin
                r_err   <= w_err;
                r_rdata <= (w_err || r_write) ? 64'd0 : w_load;
            end
        end
    end
    // Array is deliberately unreset; a reset during BUSY leaves r_state IDLE so no write fires.
    always_ff @(posedge clk) begin
        if (w_exec && !w_err && r_write)
            for (int k = 0; k < 8; k++)
                if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wsh[8*k +: 8];
    end
endmodule
